plab3_mem_write_merge_ctrl: RTL

Write-merge controller in front of the memory/cache data array. It collects word stores that target one 16-byte line into a line buffer and accumulates a 16-bit write byte enable. It emits one line-wide write when the line is complete, on a line change, on a flush, or on an idle timeout. It sits between the processor store path and the line-granular memory write port.

---
 rtl/plab3_mem_pkg.sv | 32 +++
 rtl/plab3_mem_DecoderWben.sv | 24 ++
 rtl/plab3_mem_write_merge_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/plab3_mem_pkg.sv
// ----------------------------------------------------------------------------
// plab3_mem_pkg
//   Shared constants for the line-granular store path: line/word/byte-enable
//   widths and the write-merge controller state encoding.
//   No ports (package only).
// ----------------------------------------------------------------------------
package plab3_mem_pkg;

  // A store word is always 4 bytes; a line is 4 words (16 bytes).
  localparam int unsigned c_word_bytes   = 4;
  localparam int unsigned c_line_words   = 4;
  localparam int unsigned c_line_bytes   = c_word_bytes * c_line_words;
  localparam int unsigned c_wben_nbits   = c_line_bytes;
  localparam int unsigned c_word_nbits   = 8 * c_word_bytes;
  localparam int unsigned c_line_nbits   = c_word_nbits * c_line_words;
  localparam int unsigned c_offset_nbits = $clog2(c_line_bytes);
  localparam int unsigned c_woff_nbits   = $clog2(c_line_words);

  localparam logic [c_wben_nbits-1:0] c_wben_full = '1;

  // State encoding shared with anything that observes the controller.
  localparam logic [1:0] c_state_idle  = 2'd0;
  localparam logic [1:0] c_state_merge = 2'd1;
  localparam logic [1:0] c_state_drain = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = c_state_idle,
    MERGE = c_state_merge,
    DRAIN = c_state_drain
  } merge_state_t;

endpackage

// File: rtl/plab3_mem_DecoderWben.sv
// ----------------------------------------------------------------------------
// plab3_mem_DecoderWben
//   Turns a word offset into a byte write-enable vector: four consecutive
//   enable bits at nibble position 'sel'. Offset 2 yields 16'h0F00.
//
//   sel   in   p_in_nbits           word offset within the line
//   wben  out  4*2**p_in_nbits      one-hot-word byte enable
// ----------------------------------------------------------------------------
module plab3_mem_DecoderWben #(
  parameter int p_in_nbits = 2
) (
  input  logic [p_in_nbits-1:0]         sel,
  output logic [4*(2**p_in_nbits)-1:0]  wben
);

  localparam int c_nwords = 2 ** p_in_nbits;

  always_comb begin
    for (int i = 0; i < c_nwords; i++) begin
      wben[4*i +: 4] = {4{sel == p_in_nbits'(i)}};
    end
  end

endmodule

// File: rtl/plab3_mem_write_merge_ctrl.sv
// ----------------------------------------------------------------------------
// plab3_mem_write_merge_ctrl
//   Write-merge controller in front of the data array. Word stores to one
//   16-byte line are gathered into a line buffer with an accumulated byte
//   enable; one line-wide write is emitted when the line is full, when a
//   store targets another line, on flush, or after an idle timeout.
//
//   clk          in   1    clock, rising edge
//   reset        in   1    asynchronous reset, active low
//   req_val      in   1    store request valid
//   req_rdy      out  1    store request ready
//   req_addr     in   32   store byte address ([3:2] word, [31:4] line)
//   req_data     in   32   store data
//   flush        in   1    drain any buffered line
//   memreq_val   out  1    line write valid
//   memreq_rdy   in   1    line write ready
//   memreq_addr  out  28   line address
//   memreq_data  out  128  line data, word k at [32k+31:32k]
//   memreq_wben  out  16   byte enables, bit b covers data[8b+7:8b]
//   busy         out  1    controller holds or is draining a line
// ----------------------------------------------------------------------------
module plab3_mem_write_merge_ctrl
  import plab3_mem_pkg::*;
#(
  parameter int p_addr_nbits = 32,
  parameter int p_data_nbits = 32,
  parameter int p_line_words = 4,
  parameter int p_timeout    = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               req_val,
  output logic                               req_rdy,
  input  logic [p_addr_nbits-1:0]            req_addr,
  input  logic [p_data_nbits-1:0]            req_data,
  input  logic                               flush,
  output logic                               memreq_val,
  input  logic                               memreq_rdy,
  output logic [p_addr_nbits-5:0]            memreq_addr,
  output logic [p_line_words*p_data_nbits-1:0] memreq_data,
  output logic [p_line_words*4-1:0]          memreq_wben,
  output logic                               busy
);

  localparam int c_lnbits = p_addr_nbits - c_offset_nbits;
  localparam int c_dnbits = p_line_words * p_data_nbits;
  localparam int c_bnbits = p_line_words * 4;

  // A zero-width timer is not legal, so a disabled timeout keeps one bit.
  localparam int c_timer_nbits = (p_timeout > 0) ? $clog2(p_timeout + 1) : 1;
  localparam logic [c_timer_nbits-1:0] c_timer_last =
    (p_timeout > 0) ? c_timer_nbits'(p_timeout - 1) : '0;

  merge_state_t state, state_next;

  logic [c_lnbits-1:0]      line_reg;
  logic [c_bnbits-1:0]      wben_reg;
  logic [c_dnbits-1:0]      data_reg;
  logic [c_timer_nbits-1:0] timer;

  logic [c_lnbits-1:0]      req_line;
  logic [c_woff_nbits-1:0]  word_off;
  logic [c_bnbits-1:0]      word_wben;
  logic [c_bnbits-1:0]      wben_merged;
  logic [c_dnbits-1:0]      byte_mask;
  logic [c_dnbits-1:0]      data_slot;
  logic                     line_match;
  logic                     timeout_hit;
  logic                     req_go;
  logic                     unused_addr_bits;

  assign req_line         = req_addr[p_addr_nbits-1:c_offset_nbits];
  assign word_off         = req_addr[c_offset_nbits-1:2];
  assign unused_addr_bits = ^req_addr[1:0];

  plab3_mem_DecoderWben #(
    .p_in_nbits (c_woff_nbits)
  ) u_wben_dec (
    .sel  (word_off),
    .wben (word_wben)
  );

  assign line_match  = (req_line == line_reg);
  assign wben_merged = wben_reg | word_wben;
  assign timeout_hit = (p_timeout != 0) && (timer == c_timer_last);

  // Byte-wise write mask and the store word positioned in its line slot.
  always_comb begin
    byte_mask = '0;
    data_slot = '0;
    for (int b = 0; b < c_bnbits; b++) begin
      byte_mask[8*b +: 8] = {8{word_wben[b]}};
    end
    data_slot[word_off*p_data_nbits +: p_data_nbits] = req_data;
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    req_rdy    = 1'b0;
    memreq_val = 1'b0;

    case (state)
      IDLE:  req_rdy = 1'b1;
      // flush and a full line both block acceptance; a store to another line
      // stalls until the current line has drained.
      MERGE: req_rdy = line_match && !flush && (wben_reg != c_wben_full);
      DRAIN: memreq_val = 1'b1;
      default: ;
    endcase

    req_go = req_val && req_rdy;

    case (state)
      IDLE: begin
        if (req_go) state_next = MERGE;
      end
      MERGE: begin
        if (req_go) begin
          if (wben_merged == c_wben_full) state_next = DRAIN;
        end else if (flush || (req_val && !line_match) || timeout_hit) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (memreq_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // --------------------------------------------------------------------------
  // Line buffer datapath
  // --------------------------------------------------------------------------
  // NOTE: the line data buffer is reset (not left as uninitialised storage)
  // because bytes never written must be presented as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_reg <= '0;
      wben_reg <= '0;
      data_reg <= '0;
      timer    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_go) begin
            line_reg <= req_line;
            wben_reg <= word_wben;
            data_reg <= data_slot;
            timer    <= '0;
          end
        end
        MERGE: begin
          if (req_go) begin
            // Later store to the same word replaces the earlier one.
            data_reg <= (data_reg & ~byte_mask) | data_slot;
            wben_reg <= wben_merged;
            timer    <= '0;
          end else if (timer != '1) begin
            timer <= timer + c_timer_nbits'(1);
          end
        end
        DRAIN: begin
          if (memreq_rdy) begin
            wben_reg <= '0;
            data_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign memreq_addr = line_reg;
  assign memreq_data = data_reg;
  assign memreq_wben = wben_reg;
  assign busy        = (state != IDLE);

endmodule
